// File: rtl/regfile_sequencer.sv
// regfile_sequencer: 4-state control FSM (IDLE/READ/EXEC/WRITE) driving a 16x32 register file.
// Optional macro REGSEQ_PERF_CNT_EN adds a 16-bit retired-instruction counter output.
module regfile_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] imm,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addrA,
    output logic [ADDR_W-1:0] rf_addrB,
    output logic [ADDR_W-1:0] rf_addrIn,
    output logic [DATA_W-1:0] rf_regIn,
    input  logic [DATA_W-1:0] rf_A,
    input  logic [DATA_W-1:0] rf_B,
    output logic              done,
    output logic [DATA_W-1:0] result
`ifdef REGSEQ_PERF_CNT_EN
    ,
    output logic [15:0]       retired_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [1:0]        state_q,  state_d;
    logic [2:0]        op_q,     op_d;
    logic [ADDR_W-1:0] rd_q,     rd_d;
    logic [DATA_W-1:0] imm_q,    imm_d;
    logic [ADDR_W-1:0] addrA_q,  addrA_d;
    logic [ADDR_W-1:0] addrB_q,  addrB_d;
    logic [ADDR_W-1:0] addrIn_q, addrIn_d;
    logic [DATA_W-1:0] regIn_q,  regIn_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] alu_res;

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = rf_A + rf_B;
            OP_SUB:  alu_res = rf_A - rf_B;
            OP_AND:  alu_res = rf_A & rf_B;
            OP_OR:   alu_res = rf_A | rf_B;
            OP_XOR:  alu_res = rf_A ^ rf_B;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(rf_A) < $signed(rf_B))};
            OP_SLL:  alu_res = rf_A << rf_B[SH_W-1:0];
            OP_LDI:  alu_res = imm_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        addrA_d  = addrA_q;
        addrB_d  = addrB_q;
        addrIn_d = addrIn_q;
        regIn_d  = regIn_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d    = op;
                    rd_d    = rd;
                    imm_d   = imm;
                    addrA_d = rs;
                    addrB_d = rt;
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC: begin
                result_d = alu_res;
                regIn_d  = alu_res;
                addrIn_d = rd_q;
                state_d  = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            addrA_q  <= '0;
            addrB_q  <= '0;
            addrIn_q <= '0;
            regIn_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            addrA_q  <= addrA_d;
            addrB_q  <= addrB_d;
            addrIn_q <= addrIn_d;
            regIn_q  <= regIn_d;
            result_q <= result_d;
        end
    end

    // Strobes decode from state so an async reset kills a pending write immediately.
    assign instr_ready = (state_q == S_IDLE);
    assign rf_we       = (state_q != S_WRITE);
    assign done        = (state_q == S_WRITE);
    assign rf_addrA    = addrA_q;
    assign rf_addrB    = addrB_q;
    assign rf_addrIn   = addrIn_q;
    assign rf_regIn    = regIn_q;
    assign result      = result_q;

`ifdef REGSEQ_PERF_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_WRITE) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign retired_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file, vector table, corner sequences
// and randomized instructions checked against a shadow-register reference model.
module tb_regfile_sequencer;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  op = '0;
    logic [3:0]  rs = '0, rt = '0, rd = '0;
    logic [31:0] imm = '0;
    logic        rf_we;
    logic [3:0]  rf_addrA, rf_addrB, rf_addrIn;
    logic [31:0] rf_regIn;
    logic [31:0] rf_A = '0, rf_B = '0;
    logic        done;
    logic [31:0] result;
`ifdef REGSEQ_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif

    regfile_sequencer #(.DATA_W(32), .ADDR_W(4)) dut (
        .Clk(Clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .rf_we(rf_we), .rf_addrA(rf_addrA), .rf_addrB(rf_addrB), .rf_addrIn(rf_addrIn),
        .rf_regIn(rf_regIn), .rf_A(rf_A), .rf_B(rf_B), .done(done), .result(result)
`ifdef REGSEQ_PERF_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Register file: writes when we=0, otherwise registers the A/B read ports.
    logic [31:0] regs [16] = '{default: '0};
    always @(posedge Clk) begin
        if (!rf_we) regs[rf_addrIn] <= rf_regIn;
        else begin
            rf_A <= regs[rf_addrA];
            rf_B <= regs[rf_addrB];
        end
    end

    logic [31:0] shadow [16] = '{default: '0};
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rs, rt, rd;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] im);
        int sa, sb;
        sa = a;
        sb = b;
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << (b % 32);
            default: return im;
        endcase
    endfunction

    task automatic do_instr(input logic [2:0] o, input logic [3:0] s, input logic [3:0] t,
                            input logic [3:0] d, input logic [31:0] im, input logic [31:0] exp);
        int unsigned w;
        @(negedge Clk);
        op = o; rs = s; rt = t; rd = d; imm = im; instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge Clk);
            w++;
        end
        if (!instr_ready) begin
            check("accept_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge Clk);
        #1;
        instr_valid = 1'b0;
        op = 3'($urandom); rs = 4'($urandom); rt = 4'($urandom); rd = 4'($urandom); imm = $urandom;
        @(negedge Clk);
        check("read_we", 32'(rf_we), 32'd1);
        check("read_ready", 32'(instr_ready), 32'd0);
        check("read_addrA", 32'(rf_addrA), 32'(s));
        check("read_addrB", 32'(rf_addrB), 32'(t));
        @(negedge Clk);
        check("exec_we", 32'(rf_we), 32'd1);
        check("exec_done", 32'(done), 32'd0);
        @(negedge Clk);
        check("write_we", 32'(rf_we), 32'd0);
        check("write_done", 32'(done), 32'd1);
        check("write_addrIn", 32'(rf_addrIn), 32'(d));
        check("write_regIn", rf_regIn, exp);
        check("write_result", result, exp);
        @(negedge Clk);
        check("post_done", 32'(done), 32'd0);
        check("post_we", 32'(rf_we), 32'd1);
        check("post_result_hold", result, exp);
        check("rf_contents", regs[d], exp);
        shadow[d] = exp;
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
    endtask

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{3'd7, 4'd0, 4'd0, 4'd1,  32'h0000_0005, 32'h0000_0005};
        tbl[1]  = '{3'd7, 4'd0, 4'd0, 4'd2,  32'h0000_0003, 32'h0000_0003};
        tbl[2]  = '{3'd1, 4'd1, 4'd2, 4'd8,  32'h0,         32'h0000_0002};
        tbl[3]  = '{3'd5, 4'd2, 4'd1, 4'd9,  32'h0,         32'h0000_0001};
        tbl[4]  = '{3'd5, 4'd1, 4'd2, 4'd9,  32'h0,         32'h0000_0000};
        tbl[5]  = '{3'd7, 4'd0, 4'd0, 4'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[6]  = '{3'd7, 4'd0, 4'd0, 4'd4,  32'h0000_0001, 32'h0000_0001};
        tbl[7]  = '{3'd0, 4'd3, 4'd4, 4'd3,  32'h0,         32'h0000_0000};
        tbl[8]  = '{3'd7, 4'd0, 4'd0, 4'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[9]  = '{3'd5, 4'd3, 4'd4, 4'd10, 32'h0,         32'h0000_0001};
        tbl[10] = '{3'd7, 4'd0, 4'd0, 4'd6,  32'h0000_0021, 32'h0000_0021};
        tbl[11] = '{3'd6, 4'd4, 4'd6, 4'd11, 32'h0,         32'h0000_0002};
        tbl[12] = '{3'd0, 4'd1, 4'd1, 4'd1,  32'h0,         32'h0000_000A};
        tbl[13] = '{3'd1, 4'd1, 4'd2, 4'd2,  32'h0,         32'h0000_0007};
        tbl[14] = '{3'd5, 4'd4, 4'd3, 4'd12, 32'h0,         32'h0000_0000};
        tbl[15] = '{3'd1, 4'd4, 4'd1, 4'd13, 32'h0,         32'hFFFF_FFF7};

        repeat (3) @(negedge Clk);
        check("rst_we", 32'(rf_we), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_addrA", 32'(rf_addrA), 32'd0);
        check("rst_addrB", 32'(rf_addrB), 32'd0);
        check("rst_addrIn", 32'(rf_addrIn), 32'd0);
        check("rst_regIn", rf_regIn, 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b0;

        // Reset asserted while the LDI sits in WRITE: the write must be dropped.
        @(negedge Clk);
        op = 3'd7; rs = 4'd7; rt = 4'd9; rd = 4'd5; imm = 32'hDEAD_BEEF; instr_valid = 1'b1;
        @(posedge Clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge Clk);
        check("abort_in_write", 32'(rf_we), 32'd0);
        reset = 1'b1;
        #1;
        check("abort_we", 32'(rf_we), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_addrA", 32'(rf_addrA), 32'd0);
        check("abort_addrIn", 32'(rf_addrIn), 32'd0);
        check("abort_regIn", rf_regIn, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge Clk);
        reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("abort_s5", regs[5], 32'd0);
        check("abort_idle_done", 32'(done), 32'd0);

        for (int i = 0; i < 16; i++)
            do_instr(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].exp);

        // Back-to-back requests with instr_valid held high.
        @(negedge Clk);
        op = 3'd7; rd = 4'd14; imm = 32'h0000_0077; instr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            check("bb_ready", 32'(instr_ready), (c % 4 == 0) ? 32'd1 : 32'd0);
            check("bb_we", 32'(rf_we), (c % 4 == 3) ? 32'd0 : 32'd1);
            @(negedge Clk);
        end
        instr_valid = 1'b0;
        repeat (5) @(negedge Clk);
        check("bb_s14", regs[14], 32'h0000_0077);
        shadow[14] = 32'h0000_0077;

        for (int i = 0; i < 48; i++) begin
            logic [2:0]  o;
            logic [3:0]  s, t, d;
            logic [31:0] im;
            o = 3'($urandom); s = 4'($urandom); t = 4'($urandom); d = 4'($urandom);
            im = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            do_instr(o, s, t, d, im, model(o, shadow[s], shadow[t], im));
        end

`ifdef REGSEQ_PERF_CNT_EN
        pulse_reset();
        check("cnt_after_reset", 32'(retired_cnt), 32'd0);
        for (int i = 0; i < 3; i++)
            do_instr(3'd7, 4'd0, 4'd0, 4'd15, 32'(i), 32'(i));
        check("cnt_three", 32'(retired_cnt), 32'd3);
        pulse_reset();
        check("cnt_cleared", 32'(retired_cnt), 32'd0);
`else
        pulse_reset();
        check("final_reset_we", 32'(rf_we), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Upstream control stage for the 16-entry x 32-bit register file (s0–s7 at addresses 0–7, t0–t7 at addresses 8–15).
- Accepts one register-register instruction per handshake and drives the register-file ports: `we`, `addressA`, `addressB`, `addressIn`, `regIn`.
- Consumes the registered `A`/`B` read data, computes the ALU result and writes it back to the destination register.
- Fixed 4-state FSM; one instruction in flight at a time.

Parameters:
- DATA_W, 32, datapath width; must match register-file width.
- ADDR_W, 4, register address width (16 registers).

Ports:
- Clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction request.
- instr_ready  output  1  high in IDLE only.
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLL, 111 LDI.
- rs  input  ADDR_W  source A register.
- rt  input  ADDR_W  source B register.
- rd  input  ADDR_W  destination register.
- imm  input  DATA_W  immediate for LDI.
- rf_we  output  1  to register-file `we`; 1 = read, 0 = write.
- rf_addrA  output  ADDR_W  to `addressA`.
- rf_addrB  output  ADDR_W  to `addressB`.
- rf_addrIn  output  ADDR_W  to `addressIn`.
- rf_regIn  output  DATA_W  to `regIn`.
- rf_A  input  DATA_W  from register-file `A`.
- rf_B  input  DATA_W  from register-file `B`.
- done  output  1  one-cycle pulse in the WRITE state.
- result  output  DATA_W  value being written; valid while `done`=1, otherwise holds its last value.

Behaviour:
- Reset values (asynchronous): state=IDLE, rf_we=1, all address outputs 0, rf_regIn=0, result=0, done=0.
- rf_we=0 means write every cycle in the register file. The block therefore drives rf_we=0 only in WRITE and holds rf_we=1 in every other state, including reset.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs except `instr_ready`=(state==IDLE).
- IDLE: on instr_valid && instr_ready, latch op, rd and imm; load rf_addrA<=rs and rf_addrB<=rt; go to READ. Otherwise stay.
- READ (1 cycle): rf_we=1 with stable addresses; the register file captures A/B at the closing edge; go to EXEC.
- EXEC (1 cycle): rf_A/rf_B are valid. Compute the result and register it into result and rf_regIn; set rf_addrIn<=rd; go to WRITE.
- WRITE (1 cycle): rf_we=0 and done=1; the register file writes at the closing edge; go to IDLE.
- Latency: accept edge to write edge = 3 clocks; throughput = 1 instruction per 4 clocks.
- Arithmetic: ADD/SUB are modulo 2^32 with no overflow flag.
- SLT: result 1 if A<B as signed two's complement, else 0.
- SLL: A << B[4:0]; upper bits of B are ignored.
- LDI: result=imm; A/B are ignored but the full READ/EXEC/WRITE path is taken, so latency is uniform.
- rd==rs or rd==rt is legal: the operands are read before the write.
- instr_valid while not IDLE is ignored (instr_ready=0); the request must be held until accepted.
- Reset mid-operation: outputs return to reset values immediately. A pending write is aborted because rf_we forces to 1 asynchronously. done is never asserted for the aborted instruction.

Optional Feature:
- Macro: REGSEQ_PERF_CNT_EN.
- Defined: adds output `retired_cnt` (16 bits). It increments at each WRITE-state edge, wraps 0xFFFF->0, and clears on reset.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- After reset release, LDI rd=1 imm=0x0000_0005: rf_we=0 exactly 3 edges after accept, rf_addrIn=1, rf_regIn=5, done pulses once; s1 reads back 5.
- Load s1=5 and s2=3, then SUB rd=8 rs=1 rt=2: result=2, written to t0. Then SLT rd=9 rs=2 rt=1 gives 1, and SLT rd=9 rs=1 rt=2 gives 0.
- Load s3=0xFFFF_FFFF, s4=1, then ADD rd=3 rs=3 rt=4: result=0 (wrap). Then SLT rs=3 rt=4 gives 1 (signed -1<1). Then SLL s4 by B=0x0000_0021 gives 2 (shift 1).
- Hold instr_valid high continuously: instr_ready high only every 4th cycle; exactly one accept per 4 clocks; rf_we low exactly 1 cycle in 4.
- Assert reset during WRITE of LDI rd=5 imm=0xDEAD_BEEF: rf_we=1 immediately, done stays 0, s5 remains 0.
- With REGSEQ_PERF_CNT_EN: run 3 instructions, then retired_cnt=3; reset, then retired_cnt=0.
